fifo_rd_packer: RTL
===================

Name: fifo_rd_packer

Overview:
- Read-domain consumer that sits directly downstream of the async FIFO read port.
- Drains DATA_WIDTH-bit entries from the FIFO whenever it is non-empty and packs PACK consecutive entries into one little-endian word.
- Presents each word on a valid/ready output interface.
- Lets the FIFO bench run continuous, back-pressured reads without a behavioural read model.

Parameters:
- DATA_WIDTH, 8: FIFO entry width; must match the FIFO's DATA_WIDTH.
- PACK, 4: entries per output word; legal values 2..8.
- TIMEOUT, 16: idle cycles before a partial word is flushed. Used only with the optional feature.

Ports:
- rclk  in  1  read-domain clock; all logic is on the rising edge.
- rrst  in  1  asynchronous, active-high reset.
- rempty  in  1  FIFO empty flag, already synchronous to rclk.
- rdata  in  DATA_WIDTH  FIFO read data; valid in the same cycle rempty=0 (show-ahead).
- rinc  out  1  FIFO pop; combinational.
- out_data  out  DATA_WIDTH*PACK  packed word; entry 0 in the LSBs.
- out_keep  out  PACK  per-entry valid mask.
- out_valid  out  1  word available.
- out_ready  in  1  downstream accept.
- word_cnt  out  16  count of words accepted downstream; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (rrst=1, asynchronous): the following all go to 0 immediately and stay 0 while rrst is high:
  - out_valid, out_data, out_keep, word_cnt
  - lane index idx and the assembly register
  - state = FILL
  - rinc
- A reset in mid-word discards the partial word. No pop is issued during reset.
- The design has two states, FILL and HOLD.
- Pop rule: rinc = !rempty && (state==FILL || (out_valid && out_ready)). rinc is never asserted when rempty=1.
- Data path on a pop:
  - rdata is written into assembly lane idx.
  - idx then increments.
  - When idx==PACK-1 on a pop, the completed assembly word (including the current rdata) loads out_data.
  - On that same completion pop: out_keep <= all ones, out_valid <= 1 on the next edge, idx <= 0, state <= HOLD.
- Latency: the last entry popped at edge N appears on out_data/out_valid after edge N.
- HOLD state:
  - out_data, out_keep and out_valid are stable until out_valid && out_ready.
  - The assembly register is separate from out_data, so popping lane 0 during the accept cycle does not corrupt the held word.
- On accept:
  - word_cnt increments.
  - If no new word completes in the same cycle, out_valid <= 0 and state <= FILL.
  - If a word completes in the same cycle (PACK==1 is illegal, so this cannot happen), the rule is still defined: the load wins.
- Throughput: with rempty=0 and out_ready=1 continuously, one word every PACK cycles with no bubble.
- Back-pressure: with out_ready=0 in HOLD there are no pops, and the FIFO fills upstream.
- rempty toggling mid-word: idx holds its value; there is no timeout and no flush without the optional feature.

Optional Feature:
- Macro: FIFO_RD_PACKER_FLUSH_EN.
- When defined:
  - A 16-bit idle counter runs in FILL with idx>0. It resets on every pop.
  - When it reaches TIMEOUT, the partial word loads out_data with unused lanes set to 0.
  - out_keep gets ones only for lanes 0..idx-1, out_valid <= 1, idx <= 0, state <= HOLD.
  - A pop in the same cycle as the timeout takes priority; the flush does not occur.
- When not defined:
  - No idle counter exists.
  - out_keep is all ones whenever out_valid=1.
  - A partial word waits indefinitely.

Test Plan:
1. Reset then steady stream: FIFO preloaded 0x01..0x08, out_ready=1 -> out_data=0x04030201, then 0x08070605, 4 cycles apart. out_keep=4'hF, word_cnt=2.
2. Back-pressure: 0x11..0x18 preloaded, out_ready=0 for 10 cycles after the first word -> out_data held at 0x14131211, rinc=0 throughout. After release, the second word 0x18171615 follows.
3. Empty gaps: one entry (0xA0..0xA3) written every 5 cycles -> rinc only while rempty=0. The word 0xA3A2A1A0 completes after the fourth pop.
4. Mid-word reset: pop 0x55,0x66, then pulse rrst for 1 cycle, then feed 0x01..0x04 -> out_data=0x04030201 with no 0x55/0x66. word_cnt restarts at 0.
5. word_cnt wrap: force 16'hFFFF, accept one word -> word_cnt=0.
6. With FIFO_RD_PACKER_FLUSH_EN: pop 0xC1,0xC2, then empty, TIMEOUT=16 -> 16 idle cycles later out_data=0x0000C2C1, out_keep=4'b0011.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer_if
// Groups the FIFO read-port handshake and the packed-word valid/ready output
// of fifo_rd_packer into one bundle.
//   master : packer side (drives rinc and the packed-word outputs)
//   slave  : environment side (drives the FIFO status/data and out_ready)
// Signals:
//   rempty    FIFO empty flag (rclk domain)
//   rdata     FIFO show-ahead read data
//   rinc      FIFO pop
//   out_data  packed word, entry 0 in the LSBs
//   out_keep  per-entry valid mask
//   out_valid word available
//   out_ready downstream accept
//   word_cnt  count of accepted words (wraps)
// -----------------------------------------------------------------------------
interface fifo_rd_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
);
  logic                       rempty;
  logic [DATA_WIDTH-1:0]      rdata;
  logic                       rinc;
  logic [DATA_WIDTH*PACK-1:0] out_data;
  logic [PACK-1:0]            out_keep;
  logic                       out_valid;
  logic                       out_ready;
  logic [15:0]                word_cnt;

  modport master (
    input  rempty, rdata, out_ready,
    output rinc, out_data, out_keep, out_valid, word_cnt
  );

  modport slave (
    output rempty, rdata, out_ready,
    input  rinc, out_data, out_keep, out_valid, word_cnt
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
// Read-domain consumer for an async FIFO: pops entries whenever the FIFO is
// non-empty and packs PACK consecutive entries into one little-endian word
// presented on a valid/ready output.
// Ports:
//   rclk  read-domain clock (rising edge)
//   rrst  asynchronous active-high reset; also blocks rinc while high
//   bus   fifo_rd_packer_if.master (FIFO read port + packed-word output)
// Optional feature (macro FIFO_RD_PACKER_FLUSH_EN): a partial word that sees
// TIMEOUT idle cycles is flushed with unused lanes zeroed and out_keep
// marking only the filled lanes.
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                rclk,
  input  logic                rrst,
  fifo_rd_packer_if.master    bus
);

  localparam int IDX_W  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int WORD_W = DATA_WIDTH * PACK;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                          r_state;
  logic [IDX_W-1:0]                r_idx;
  logic [PACK-1:0][DATA_WIDTH-1:0] r_asm;
  logic [WORD_W-1:0]               r_out_data;
  logic [PACK-1:0]                 r_out_keep;
  logic                            r_out_valid;
  logic [15:0]                     r_word_cnt;

  logic                            w_accept;
  logic                            w_pop;
  logic                            w_last;
  logic [WORD_W-1:0]               w_full_word;

  assign w_accept = r_out_valid & bus.out_ready;
  // Reset gates the pop so nothing is drained while rrst is high.
  assign w_pop    = ~rrst & ~bus.rempty & ((r_state == ST_FILL) | w_accept);
  assign w_last   = w_pop & (r_idx == LAST_IDX);

  assign bus.rinc      = w_pop;
  assign bus.out_data  = r_out_data;
  assign bus.out_keep  = r_out_keep;
  assign bus.out_valid = r_out_valid;
  assign bus.word_cnt  = r_word_cnt;

  // Completed word: stored lanes, with the lane being popped taken from rdata.
  always_comb begin
    w_full_word = {WORD_W{1'b0}};
    for (int i = 0; i < PACK; i++) begin
      if (i == int'(r_idx)) begin
        w_full_word[i*DATA_WIDTH +: DATA_WIDTH] = bus.rdata;
      end else begin
        w_full_word[i*DATA_WIDTH +: DATA_WIDTH] = r_asm[i];
      end
    end
  end

`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic [15:0]       r_idle;
  logic              w_timeout;
  logic [WORD_W-1:0] w_part_word;
  logic [PACK-1:0]   w_part_keep;

  // Fires on the TIMEOUT-th consecutive idle edge of a partial word.
  assign w_timeout = (r_state == ST_FILL) & (r_idx != IDX_ZERO) & ~w_pop &
                     (r_idle == 16'(TIMEOUT - 1));

  // Partial word: lanes below idx are valid, the rest (possibly stale) are zeroed.
  always_comb begin
    w_part_word = {WORD_W{1'b0}};
    w_part_keep = {PACK{1'b0}};
    for (int i = 0; i < PACK; i++) begin
      if (i < int'(r_idx)) begin
        w_part_word[i*DATA_WIDTH +: DATA_WIDTH] = r_asm[i];
        w_part_keep[i] = 1'b1;
      end else begin
        w_part_word[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
        w_part_keep[i] = 1'b0;
      end
    end
  end

  // Idle counter: counts non-pop cycles while a partial word sits in FILL.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_idle <= 16'd0;
    end else if ((r_state == ST_FILL) && (r_idx != IDX_ZERO) && !w_pop && !w_timeout) begin
      r_idle <= r_idle + 16'd1;
    end else begin
      r_idle <= 16'd0;
    end
  end
`endif

  // Packer FSM, assembly register, output word and accepted-word counter.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_state     <= ST_FILL;
      r_idx       <= IDX_ZERO;
      r_asm       <= {WORD_W{1'b0}};
      r_out_data  <= {WORD_W{1'b0}};
      r_out_keep  <= {PACK{1'b0}};
      r_out_valid <= 1'b0;
      r_word_cnt  <= 16'd0;
    end else begin
      if (w_pop) begin
        r_asm[r_idx] <= bus.rdata;
      end
      r_word_cnt <= r_word_cnt + {15'd0, w_accept};
      case (r_state)
        ST_FILL: begin
          if (w_last) begin
            r_out_data  <= w_full_word;
            r_out_keep  <= {PACK{1'b1}};
            r_out_valid <= 1'b1;
            r_idx       <= IDX_ZERO;
            r_state     <= ST_HOLD;
          end
`ifdef FIFO_RD_PACKER_FLUSH_EN
          else if (w_timeout) begin
            r_out_data  <= w_part_word;
            r_out_keep  <= w_part_keep;
            r_out_valid <= 1'b1;
            r_idx       <= IDX_ZERO;
            r_state     <= ST_HOLD;
          end
`endif
          else if (w_pop) begin
            r_idx <= r_idx + IDX_ONE;
          end else begin
            r_idx <= r_idx;
          end
        end
        ST_HOLD: begin
          // A completion in the accept cycle would win; unreachable for PACK>=2.
          if (w_last) begin
            r_out_data  <= w_full_word;
            r_out_keep  <= {PACK{1'b1}};
            r_out_valid <= 1'b1;
            r_idx       <= IDX_ZERO;
            r_state     <= ST_HOLD;
          end else if (w_accept) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_FILL;
            if (w_pop) begin
              r_idx <= r_idx + IDX_ONE;
            end else begin
              r_idx <= r_idx;
            end
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: begin
          r_state <= ST_FILL;
        end
      endcase
    end
  end

endmodule
